// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, d = x - y - bin, composed of two half-subtractor stages.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // stage 1: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;

    // stage 2: (x - y) - bin
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; results registered when the last bit completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bflop;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bout;
    logic             last;
    logic [WIDTH:0]   cat;
    logic [WIDTH-1:0] res_nxt;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bflop),
        .d    (d),
        .bout (bout)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    // new bit enters at the MSB end; after WIDTH shifts the LSB has reached bit 0
    assign cat     = {d, res};
    assign res_nxt = cat[WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            bflop      <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bflop <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_nxt;
                    bflop <= bout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // a_sh[0]/b_sh[0] are the operand sign bits here, d is the result sign
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_nxt;
                        borrow_out <= bout;
                        overflow   <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model compared every cycle plus directed cases.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow_out, overflow;
    logic [7:0] diff;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, borrow_out1, overflow1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .overflow(overflow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1),
        .borrow_out(borrow_out1), .overflow(overflow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a start seen while not busy takes 8 cycles, then results appear with done.
    int         m_rem;
    logic       m_done, m_bo, m_ov, p_bo, p_ov;
    logic [7:0] m_diff, p_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bo   <= 1'b0;
            m_ov   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_diff <= p_diff;
                    m_bo   <= p_bo;
                    m_ov   <= p_ov;
                end
            end else if (start) begin
                int sa, sb, sd;
                sa = a[7] ? int'(a) - 256 : int'(a);
                sb = b[7] ? int'(b) - 256 : int'(b);
                sd = sa - sb;
                m_rem  <= 8;
                p_diff <= 8'((int'(a) - int'(b)) & 255);
                p_bo   <= (a < b);
                p_ov   <= (sd > 127) || (sd < -128);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("cyc_busy", 32'(busy), 32'(m_rem > 0));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_diff", 32'(diff), 32'(m_diff));
            chk("cyc_borrow", 32'(borrow_out), 32'(m_bo));
            chk("cyc_ovf", 32'(overflow), 32'(m_ov));
        end
    end

    // One-cycle start, then count busy cycles until done (bounded) and check literal results.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int  nb;
        bit  seen;
        nb   = 0;
        seen = 0;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (busy) nb++;
            if (done) seen = 1;
        end
        chk("op_done_seen", 32'(seen), 32'd1);
        chk("op_busy_cycles", 32'(nb), 32'd8);
        chk("op_diff", 32'(diff), 32'(ed));
        chk("op_borrow", 32'(borrow_out), 32'(eb));
        chk("op_ovf", 32'(overflow), 32'(eo));
        chk("model_diff", 32'(m_diff), 32'(ed));
        chk("model_ovf", 32'(m_ov), 32'(eo));
    endtask

    initial begin
        int  t0, nb;
        bit  seen;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start held: a change during SHIFT is ignored, re-accepted straight out of DONE
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd4;
        seen = 0; t0 = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(posedge clk); #2;
            if (i == 3) a = 8'd0;
            if (done) begin seen = 1; t0 = i; end
        end
        chk("held_done1", 32'(seen), 32'd1);
        chk("held_diff1", 32'(diff), 32'h05);
        seen = 0; nb = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(posedge clk); #2;
            if (done) begin seen = 1; nb = i; end
        end
        start = 1'b0;
        chk("held_done2", 32'(seen), 32'd1);
        chk("held_period", 32'(nb), 32'd9);
        chk("held_diff2", 32'(diff), 32'hFC);
        chk("held_borrow2", 32'(borrow_out), 32'd1);

        // reset in the 4th SHIFT cycle abandons the operation
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrow_out), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            chk("no_done_after_rst", 32'(done), 32'd0);
        end
        run_op(8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

        // single-bit instance
        @(negedge clk);
        start1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        seen = 0; nb = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #2;
            start1 = 1'b0;
            if (busy1) nb++;
            if (done1) seen = 1;
        end
        chk("w1_done", 32'(seen), 32'd1);
        chk("w1_busy_cycles", 32'(nb), 32'd1);
        chk("w1_diff", 32'(diff1), 32'd1);
        chk("w1_borrow", 32'(borrow_out1), 32'd1);
        chk("w1_ovf", 32'(overflow1), 32'd1);
        @(posedge clk); #2;
        chk("w1_done_pulse", 32'(done1), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
